negedge_serial_tx: RTL and testbench
====================================

# negedge_serial_tx

- Serial transmitter, the driving end of a single-wire link whose receiver is a rising-edge sampling flip-flop on the same clock.
- Accepts a parallel word over a valid/ready handshake and frames it as start bit, data bits LSB-first, optional even parity, then stop bit. Sends one bit per clock.
- Each bit is launched on the falling edge of `clk`, so it is stable a half-cycle before the receiver samples on the rising edge.
- Sits between a word producer and any posedge capture register or deserializer.

## Interface
Parameters:
- WIDTH, 8, data bits per frame (≥2)

Ports:
- clk  input  1  system clock; FSM and handshake logic on posedge, `sout` on negedge
- rst  input  1  synchronous, active-high reset, sampled on posedge `clk`
- din  input  WIDTH  parallel word to send
- din_valid  input  1  producer has a word on `din`
- din_ready  output  1  transmitter can accept a word (registered)
- sout  output  1  serial line, idle high, launched on negedge `clk`
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse when a frame completes

## Operation
- FSM on posedge with states IDLE, START, DATA, PARITY, STOP. PARITY exists only with the macro defined.
- Internal posedge register `tx_bit` is the bit to launch.
- Negedge register: `sout <= tx_bit`.
- IDLE:
  - `tx_bit`=1, `din_ready`=1.
  - On `din_valid && din_ready`, capture `din` into the shift register, go to START, set `tx_bit`=0 and `busy`=1.
- START: lasts 1 cycle, then go to DATA with `tx_bit`=shreg[0] and bit counter 0.
- DATA:
  - Each cycle: shift right, counter+1, `tx_bit`=next LSB.
  - When counter = WIDTH-1, go to PARITY (`tx_bit`=XOR of the captured word) or to STOP (`tx_bit`=1).
- PARITY: lasts 1 cycle, then go to STOP with `tx_bit`=1.
- STOP: lasts 1 cycle, then go to IDLE. `done`=1 and `busy`=0 for exactly the next cycle.
- `din` is captured at acceptance and may change afterwards.
- `din_valid` outside IDLE is ignored; `din_ready`=0 then.
- The bit counter is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
- Reset, including mid-frame, at the sampled posedge:
  - state=IDLE, `tx_bit`=1, counter=0, `busy`=0, `done`=0, `din_ready`=0.
  - The partial frame is abandoned; there is no `done` pulse for it.
  - `din_ready` rises at the first posedge with `rst` low.

## Timing
- Reset values:
  - `din_ready`=0, `busy`=0, `done`=0.
  - `sout`=1 from the first negedge after reset is sampled. `sout` is X before that.
- Accept at posedge k:
  - `sout`=0 (start) from negedge k+0.5; the receiver samples it at posedge k+1.
  - Data bit i is sampled at posedge k+2+i.
  - Parity bit, if built, is sampled at k+2+WIDTH.
  - Stop bit is sampled at k+2+WIDTH+P, where P=1 with parity and 0 without.
- `done` is high in the cycle after posedge k+3+WIDTH+P−1 (the posedge that leaves STOP).
- `din_ready` is high again from that same posedge. The earliest next accept is one posedge later.
- Frame period is WIDTH+3+P cycles, including 1 idle-high gap cycle.
- `busy` is high from posedge k until the posedge that leaves STOP.

## Configuration
- SERIAL_TX_PARITY_EN:
  - Defined: PARITY state is compiled in; one even-parity bit (XOR of data) is sent after the MSB, and the frame is WIDTH+3 bits.
  - Undefined: PARITY state, parity logic and the P=1 timing are absent; the frame is WIDTH+2 bits.

## Test plan
- Reset: hold `rst` high 3 cycles -> `din_ready`=0, `busy`=0, `done`=0, `sout`=1 after the first negedge; `din_ready`=1 one posedge after `rst` falls.
- WIDTH=8, no parity, send 0xA5 accepted at posedge k -> posedge-sampled `sout` at k+1..k+10 = 0,1,0,1,0,0,1,0,1,1; `done` pulse once; `busy` high for exactly 10 cycles.
- Back-to-back 0x00 then 0xFF with `din_valid` held high -> second start bit is sampled 11 cycles after the first; exactly one idle-high gap cycle between frames.
- Change `din` and pulse `din_valid` mid-frame -> no acceptance; the transmitted frame still carries the originally captured word.
- Assert `rst` for 1 cycle at data bit 3 -> `sout`=1 from the next negedge, no `done` pulse; a subsequent 0x3C frame transmits correctly.
- With SERIAL_TX_PARITY_EN, send 0x07 and 0x03 -> parity bits 1 and 0 respectively; frame 11 bits; `done` 11 cycles after accept.

Source files
------------

// File: rtl/negedge_serial_tx.sv
// Single-wire frame transmitter: start, WIDTH data bits LSB-first, optional even parity, stop.
// Optional parity bit compiled in with `define SERIAL_TX_PARITY_EN.
module negedge_serial_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [2:0]       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             tx_bit, tx_bit_nxt;
  logic             busy_nxt, done_nxt, ready_nxt;
`ifdef SERIAL_TX_PARITY_EN
  logic             par, par_nxt;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      tx_bit    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      din_ready <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      tx_bit    <= tx_bit_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      din_ready <= ready_nxt;
`ifdef SERIAL_TX_PARITY_EN
      par       <= par_nxt;
`endif
    end
  end

  // Launch half a cycle ahead of the receiver's rising-edge sample
  always_ff @(negedge clk) begin
    sout <= tx_bit;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    cnt_nxt    = cnt;
    tx_bit_nxt = tx_bit;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    ready_nxt  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_nxt    = par;
`endif

    case (state)
      S_IDLE: begin
        tx_bit_nxt = 1'b1;
        ready_nxt  = 1'b1;
        busy_nxt   = 1'b0;
        cnt_nxt    = '0;
        if (din_valid && din_ready) begin
          shreg_nxt  = din;
          state_nxt  = S_START;
          tx_bit_nxt = 1'b0;
          busy_nxt   = 1'b1;
          ready_nxt  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          par_nxt    = ^din;
`endif
        end
      end

      S_START: begin
        state_nxt  = S_DATA;
        tx_bit_nxt = shreg[0];
        cnt_nxt    = '0;
      end

      S_DATA: begin
        shreg_nxt = shreg >> 1;
        if (cnt == LAST_BIT) begin
          cnt_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
          state_nxt  = S_PARITY;
          tx_bit_nxt = par;
`else
          state_nxt  = S_STOP;
          tx_bit_nxt = 1'b1;
`endif
        end else begin
          cnt_nxt    = cnt + CW'(1);
          tx_bit_nxt = shreg[1];
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        state_nxt  = S_STOP;
        tx_bit_nxt = 1'b1;
      end
`endif

      S_STOP: begin
        state_nxt  = S_IDLE;
        tx_bit_nxt = 1'b1;
        done_nxt   = 1'b1;
        busy_nxt   = 1'b0;
        ready_nxt  = 1'b1;
      end

      default: begin
        state_nxt  = S_IDLE;
        tx_bit_nxt = 1'b1;
        busy_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_negedge_serial_tx.sv
// Directed bench for negedge_serial_tx: reset, framing, back-to-back, ignored mid-frame valid, mid-frame reset.
module tb_negedge_serial_tx;

  localparam int unsigned WIDTH = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F = WIDTH + 2 + P;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             busy;
  logic             done;

  int vecs = 0;
  int errs = 0;

  logic so_s [64];
  logic bz_s [64];
  logic dn_s [64];
  logic rd_s [64];

  negedge_serial_tx #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected line bits as sampled at k+1.., followed by idle-high
  function automatic logic [31:0] exp_frame(input logic [WIDTH-1:0] w);
    logic [31:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int b = 0; b < int'(WIDTH); b++) f[1+b] = w[b];
    if (P == 1) f[WIDTH+1] = ^w;
    return f;
  endfunction

  // Present a word and wait for acceptance; returns at accept posedge + 1
  task automatic send(input logic [WIDTH-1:0] w, input bit hold, output bit ok);
    logic rdy;
    din = w;
    din_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      rdy = din_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    if (!hold) din_valid = 1'b0;
    if (!ok) begin
      vecs++; errs++;
      $display("FAIL accept_timeout word=%h din_ready never high", w);
    end
  endtask

  // Record outputs at posedges k+1..k+n with optional stimulus changes in between
  task automatic capture(input int n, input int drop_at, input int dist_from,
                         input int dist_to, input logic [WIDTH-1:0] dist_word);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      so_s[i] = sout; bz_s[i] = busy; dn_s[i] = done; rd_s[i] = din_ready;
      if (i == drop_at) din_valid = 1'b0;
      if (i == dist_from) begin din = dist_word; din_valid = 1'b1; end
      if (i == dist_to) din_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; din_valid = 1'b0;
    @(negedge clk); #1;
    vecs++;
    if (sout !== 1'b1) begin errs++; $display("FAIL reset_sout got=%b exp=1", sout); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    vecs++;
    if (din_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got=%b exp=0", din_ready); end
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vecs++;
    if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (din_ready !== 1'b1) begin errs++; $display("FAIL reset_ready_rise got=%b exp=1", din_ready); end
  endtask

  task automatic test_frame(input logic [WIDTH-1:0] w, input bit disturb);
    bit ok;
    logic [31:0] e;
    e = exp_frame(w);
    send(w, 1'b0, ok);
    if (ok) begin
      vecs++;
      if (busy !== 1'b1) begin errs++; $display("FAIL busy_at_accept w=%h got=%b exp=1", w, busy); end
      if (disturb) capture(F + 1, 0, 2, 6, ~w);
      else         capture(F + 1, 0, 0, 0, '0);
      for (int i = 1; i <= F + 1; i++) begin
        vecs++;
        if (so_s[i] !== e[i-1])
          begin errs++; $display("FAIL sout w=%h k+%0d got=%b exp=%b", w, i, so_s[i], e[i-1]); end
        vecs++;
        if (bz_s[i] !== (i < F))
          begin errs++; $display("FAIL busy w=%h k+%0d got=%b exp=%b", w, i, bz_s[i], (i < F)); end
        vecs++;
        if (dn_s[i] !== (i == F))
          begin errs++; $display("FAIL done w=%h k+%0d got=%b exp=%b", w, i, dn_s[i], (i == F)); end
        vecs++;
        if (rd_s[i] !== (i >= F))
          begin errs++; $display("FAIL ready w=%h k+%0d got=%b exp=%b", w, i, rd_s[i], (i >= F)); end
      end
    end
  endtask

  // 0xA5 without parity, hand-derived: 0,1,0,1,0,0,1,0,1,1
  task automatic test_a5();
    bit ok;
    logic [9:0] hand;
    hand = 10'b11_0100_1010;
    test_frame(8'hA5, 1'b0);
    if (P == 0) begin
      for (int i = 1; i <= 10; i++) begin
        vecs++;
        if (so_s[i] !== hand[i-1])
          begin errs++; $display("FAIL a5_hand k+%0d got=%b exp=%b", i, so_s[i], hand[i-1]); end
      end
    end
    ok = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] e0, e1;
    logic        expb;
    e0 = exp_frame(8'h00);
    e1 = exp_frame(8'hFF);
    send(8'h00, 1'b1, ok);
    if (ok) begin
      din = 8'hFF;
      capture(2 * F + 2, F + 1, 0, 0, '0);
      for (int i = 1; i <= 2 * F + 2; i++) begin
        if (i <= F)          expb = e0[i-1];
        else if (i == F + 1) expb = 1'b1;
        else if (i <= 2*F+1) expb = e1[i-F-2];
        else                 expb = 1'b1;
        vecs++;
        if (so_s[i] !== expb)
          begin errs++; $display("FAIL b2b_sout k+%0d got=%b exp=%b", i, so_s[i], expb); end
        vecs++;
        if (dn_s[i] !== (i == F || i == 2 * F + 1))
          begin errs++; $display("FAIL b2b_done k+%0d got=%b exp=%b", i, dn_s[i], (i == F || i == 2*F+1)); end
      end
      vecs++;
      if (bz_s[F+1] !== 1'b1)
        begin errs++; $display("FAIL b2b_second_accept busy got=%b exp=1", bz_s[F+1]); end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_ignore_midframe();
    test_frame(8'h5A, 1'b1);
  endtask

  task automatic test_reset_midframe();
    bit ok;
    send(8'hC3, 1'b0, ok);
    if (ok) begin
      capture(4, 0, 0, 0, '0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vecs++;
      if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      vecs++;
      if (done !== 1'b0) begin errs++; $display("FAIL midrst_done got=%b exp=0", done); end
      vecs++;
      if (din_ready !== 1'b0) begin errs++; $display("FAIL midrst_ready got=%b exp=0", din_ready); end
      @(negedge clk); #1;
      vecs++;
      if (sout !== 1'b1) begin errs++; $display("FAIL midrst_sout got=%b exp=1", sout); end
      capture(F + 2, 0, 0, 0, '0);
      for (int i = 1; i <= F + 2; i++) begin
        vecs++;
        if (dn_s[i] !== 1'b0 || so_s[i] !== 1'b1)
          begin errs++; $display("FAIL midrst_idle c%0d done=%b sout=%b exp done=0 sout=1", i, dn_s[i], so_s[i]); end
      end
      vecs++;
      if (rd_s[1] !== 1'b1) begin errs++; $display("FAIL midrst_ready_rise got=%b exp=1", rd_s[1]); end
    end
    test_frame(8'h3C, 1'b0);
  endtask

  task automatic test_parity();
`ifdef SERIAL_TX_PARITY_EN
    test_frame(8'h07, 1'b0);
    vecs++;
    if (so_s[WIDTH+2] !== 1'b1) begin errs++; $display("FAIL parity_07 got=%b exp=1", so_s[WIDTH+2]); end
    test_frame(8'h03, 1'b0);
    vecs++;
    if (so_s[WIDTH+2] !== 1'b0) begin errs++; $display("FAIL parity_03 got=%b exp=0", so_s[WIDTH+2]); end
`endif
  endtask

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
